ofdm_subcarrier_mapper: RTL and testbench
=========================================

# ofdm_subcarrier_mapper

Sits directly downstream of the 64QAM mapper and upstream of the IFFT. Collects one OFDM symbol's worth of QAM I/Q samples into a ping-pong buffer and places them on active subcarrier bins. It then streams a full N_FFT-bin frame in natural bin order to the IFFT, with DC and guard bins forced to zero. The IFFT applies backpressure through a valid/ready handshake; the QAM side has none, so samples arriving while both banks are full are dropped and flagged.

## Interface
- N_FFT, 64, IFFT size; power of two, 16..2048.
- N_USED, 52, active (data) subcarriers per symbol; even, 2..N_FFT-2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- qam_inphase_i  in  16  signed I sample from the QAM mapper.
- qam_quadrat_i  in  16  signed Q sample.
- qam_mod_valid  in  1  sample valid; one sample per asserted cycle.
- ifft_inphase_o  out  16  signed I of the current bin.
- ifft_quadrat_o  out  16  signed Q of the current bin.
- ifft_valid  out  1  bin data valid.
- ifft_ready  in  1  IFFT accepts a bin when ifft_valid && ifft_ready.
- ifft_sop  out  1  high with bin 0 of a frame.
- ifft_eop  out  1  high with bin N_FFT-1.
- ifft_bin  out  log2(N_FFT)  current bin index.
- overflow  out  1  sticky; set when a sample is dropped.

## Operation
- Storage: two banks, each N_FFT x 32 bits, holding {I,Q}. Reads are asynchronous, so distributed RAM is acceptable.
- Write side: registers wr_bank, wr_cnt (0..N_USED-1) and bank_full[1:0].
- When qam_mod_valid is high and bank_full[wr_bank]==0, the sample is written to bank wr_bank at bin map(wr_cnt):
  - k < N_USED/2: bin N_FFT - N_USED/2 + k (negative frequencies).
  - k >= N_USED/2: bin k - N_USED/2 + 1 (positive frequencies).
- wr_cnt increments on each accepted sample.
- On the accept with wr_cnt==N_USED-1: set bank_full[wr_bank], toggle wr_bank, reset wr_cnt to 0.
- When qam_mod_valid is high and bank_full[wr_bank]==1: discard the sample, set overflow, and leave wr_cnt and wr_bank unchanged.
- Read side FSM:
  - IDLE: ifft_valid=0. Moves to STREAM with rd_idx=0 when bank_full[rd_bank]==1.
  - STREAM: ifft_valid=1, ifft_bin=rd_idx.
    - Data bins (1 <= rd_idx <= N_USED/2, or rd_idx >= N_FFT-N_USED/2): output the bank contents.
    - All other bins, including DC bin 0: output 0.
- On a transfer in STREAM, rd_idx increments.
- On the transfer at rd_idx==N_FFT-1: clear bank_full[rd_bank], toggle rd_bank, return to IDLE.
- Default geometry (64/52): data on bins 38..63 and 1..26; zero on bins 0 and 27..37.
- Bank memory is never cleared. Guard/DC zeroing is done purely by the bin-index decode.

## Timing
- Reset values: all outputs 0, overflow=0, FSM=IDLE, wr_bank=rd_bank=0, wr_cnt=rd_idx=0, bank_full=00.
- Latency: if the last sample of a symbol is accepted in cycle T, ifft_valid first rises in cycle T+2 with ifft_sop=1 and ifft_bin=0.
- Handshake:
  - ifft_valid stays high until the frame's final transfer.
  - Outputs hold stable while ifft_valid && !ifft_ready.
  - ifft_valid never drops mid-frame.
- One idle cycle (ifft_valid=0) separates consecutive frames, even when the other bank is already full.
- Simultaneous events:
  - Write completion and read release on different banks in the same cycle: both take effect.
  - Release of bank B in cycle T while a sample targets B in the same cycle: the full check uses the pre-release value, so the sample is dropped and overflow is set. B is writable from T+1.
- Throughput: with ifft_ready held high, a frame takes N_FFT+1 cycles.
  - Inputs at one sample per cycle are lossless only while N_USED >= N_FFT+1 cycles.
  - Sustained full-rate input therefore overflows; the upstream duty cycle is a system constraint.
- Reset asserted mid-operation: immediately aborts any partial write frame and any in-progress output frame, and returns all state to reset values. Stale memory contents are harmless.
- overflow clears only on reset.

## Test plan
- Ramp: feed 52 samples with I=k, Q=-k (k=0..51), ifft_ready=1.
  - First ifft_valid appears 2 cycles after the last input.
  - Bins 38..63 carry I=0..25; bins 1..26 carry I=26..51; bins 0 and 27..37 are 0.
  - sop is high at bin 0 and eop at bin 63.
- Backpressure: same ramp with ifft_ready toggled pseudo-randomly. Every bin is transferred exactly once, in order, with data stable while stalled.
- Ping-pong: feed 3 frames with ifft_ready=0, then release ready.
  - Frames 1 and 2 are output intact, separated by one idle cycle.
  - All 52 samples of frame 3 are dropped; overflow=1 from the first dropped sample.
- Boundary release: time frame 3's first sample to the exact cycle frame 1's eop transfers. That sample is dropped, overflow=1, and the next sample lands at wr_cnt=0.
- Reset mid-stream: assert reset at bin 20 of output and wr_cnt=10.
  - All outputs go to 0 asynchronously.
  - After release, a fresh 52-sample frame is output correctly with sop at bin 0.
- Sign extremes: inputs I=16'sh8000, Q=16'sh7FFF pass bit-exactly to their mapped bins.

Source files
------------

// File: rtl/ofdm_subcarrier_mapper.sv
// ----------------------------------------------------------------------------
// ofdm_subcarrier_mapper
//
// Collects one OFDM symbol of QAM I/Q samples into a ping-pong buffer, placing
// each sample on its active subcarrier bin. Each filled bank is streamed to the
// IFFT as a full N_FFT-bin frame in natural bin order. DC and guard bins are
// forced to zero by the bin-index decode. The IFFT side uses a valid/ready
// handshake. The QAM side cannot be stalled, so a sample that arrives while
// its target bank is still full is dropped and flagged in a sticky overflow bit.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low; clears all state
//   qam_inphase_i  : signed I sample from the QAM mapper
//   qam_quadrat_i  : signed Q sample from the QAM mapper
//   qam_mod_valid  : sample valid, one sample per asserted cycle
//   ifft_inphase_o : signed I of the current bin
//   ifft_quadrat_o : signed Q of the current bin
//   ifft_valid     : bin data valid
//   ifft_ready     : IFFT accepts a bin when ifft_valid && ifft_ready
//   ifft_sop       : high with bin 0 of a frame
//   ifft_eop       : high with bin N_FFT-1
//   ifft_bin       : current bin index
//   overflow       : sticky, set when a sample is dropped
// ----------------------------------------------------------------------------
module ofdm_subcarrier_mapper #(
    parameter int N_FFT  = 64,
    parameter int N_USED = 52
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [15:0]       qam_inphase_i,
    input  logic signed [15:0]       qam_quadrat_i,
    input  logic                     qam_mod_valid,
    output logic signed [15:0]       ifft_inphase_o,
    output logic signed [15:0]       ifft_quadrat_o,
    output logic                     ifft_valid,
    input  logic                     ifft_ready,
    output logic                     ifft_sop,
    output logic                     ifft_eop,
    output logic [$clog2(N_FFT)-1:0] ifft_bin,
    output logic                     overflow
);

    localparam int BW = $clog2(N_FFT);
    localparam logic [BW-1:0] HALF_B   = BW'(N_USED / 2);
    localparam logic [BW-1:0] NEG_BASE = BW'(N_FFT - N_USED / 2);
    localparam logic [BW-1:0] LAST_K   = BW'(N_USED - 1);
    localparam logic [BW-1:0] LAST_BIN = BW'(N_FFT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_e;

    // ------------------------------------------------------------------
    // Storage: both banks in one array, address = {bank, bin}.
    // ------------------------------------------------------------------
    logic [31:0] mem_q [2*N_FFT];

    // Write side
    logic          wr_bank_q, wr_bank_d;
    logic [BW-1:0] wr_cnt_q, wr_cnt_d;
    logic          overflow_q, overflow_d;
    logic          wr_en;
    logic [BW-1:0] wr_bin;
    logic [1:0]    set_full;

    // Read side
    state_e        state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic [BW-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]    clr_full;
    logic          data_bin;
    logic [31:0]   rd_word;

    // Shared
    logic [1:0]    bank_full_q, bank_full_d;

    // ------------------------------------------------------------------
    // Write side: accept or drop, and map sample index to its bin.
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        set_full   = 2'b00;
        // Lower half of the symbol goes to negative frequencies at the top of
        // the bin range, upper half to positive frequencies starting at bin 1.
        if (wr_cnt_q < HALF_B) begin
            wr_bin = NEG_BASE + wr_cnt_q;
        end else begin
            wr_bin = wr_cnt_q - HALF_B + BW'(1);
        end
        if (qam_mod_valid) begin
            // Uses the registered full flags, so a bank released this cycle
            // is still treated as full for a sample arriving in the same cycle.
            if (bank_full_q[wr_bank_q]) begin
                overflow_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (wr_cnt_q == LAST_K) begin
                    set_full[wr_bank_q] = 1'b1;
                    wr_bank_d           = ~wr_bank_q;
                    wr_cnt_d            = '0;
                end else begin
                    wr_cnt_d = wr_cnt_q + BW'(1);
                end
            end
        end
    end

    // NOTE: the sample memory has no reset; stale contents are never visible
    // because guard/DC bins are zeroed by decode and data bins are rewritten
    // before their bank is marked full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank_q, wr_bin}] <= {qam_inphase_i, qam_quadrat_i};
        end
    end

    // ------------------------------------------------------------------
    // Read side FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        clr_full  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = ST_STREAM;
                    rd_idx_d = '0;
                end
            end
            ST_STREAM: begin
                if (ifft_ready) begin
                    if (rd_idx_q == LAST_BIN) begin
                        // Returning to IDLE here gives the mandatory idle
                        // cycle between back-to-back frames.
                        clr_full[rd_bank_q] = 1'b1;
                        rd_bank_d           = ~rd_bank_q;
                        rd_idx_d            = '0;
                        state_d             = ST_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion and release always target different banks, so set and clear
    // never collide on the same bit.
    assign bank_full_d = (bank_full_q | set_full) & ~clr_full;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            bank_full_q <= 2'b00;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            bank_full_q <= bank_full_d;
            overflow_q  <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_bin = ((rd_idx_q != '0) && (rd_idx_q <= HALF_B)) || (rd_idx_q >= NEG_BASE);
    assign rd_word  = mem_q[{rd_bank_q, rd_idx_q}];

    assign ifft_valid     = (state_q == ST_STREAM);
    assign ifft_bin       = rd_idx_q;
    assign ifft_sop       = ifft_valid && (rd_idx_q == '0);
    assign ifft_eop       = ifft_valid && (rd_idx_q == LAST_BIN);
    assign ifft_inphase_o = (ifft_valid && data_bin) ? rd_word[31:16] : 16'sd0;
    assign ifft_quadrat_o = (ifft_valid && data_bin) ? rd_word[15:0]  : 16'sd0;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// ----------------------------------------------------------------------------
// Directed testbench for ofdm_subcarrier_mapper (64-point FFT, 52 used bins).
// Expected bin contents are derived from the sample lists by the inverse of the
// subcarrier placement: bins 38..63 hold samples 0..25, bins 1..26 hold
// samples 26..51, and every other bin is zero.
// ----------------------------------------------------------------------------
module tb_ofdm_subcarrier_mapper;

    localparam int N_FFT  = 64;
    localparam int N_USED = 52;
    localparam int HALF   = N_USED / 2;
    localparam int BW     = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [15:0]  qam_inphase_i;
    logic signed [15:0]  qam_quadrat_i;
    logic                qam_mod_valid;
    logic signed [15:0]  ifft_inphase_o;
    logic signed [15:0]  ifft_quadrat_o;
    logic                ifft_valid;
    logic                ifft_ready;
    logic                ifft_sop;
    logic                ifft_eop;
    logic [BW-1:0]       ifft_bin;
    logic                overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] fa [N_USED];
    logic [31:0] fb [N_USED];
    logic [31:0] fc [N_USED];
    logic [31:0] fd [N_USED];
    logic [31:0] fs [N_USED];

    ofdm_subcarrier_mapper #(.N_FFT(N_FFT), .N_USED(N_USED)) dut (
        .clk            (clk),
        .reset          (reset),
        .qam_inphase_i  (qam_inphase_i),
        .qam_quadrat_i  (qam_quadrat_i),
        .qam_mod_valid  (qam_mod_valid),
        .ifft_inphase_o (ifft_inphase_o),
        .ifft_quadrat_o (ifft_quadrat_o),
        .ifft_valid     (ifft_valid),
        .ifft_ready     (ifft_ready),
        .ifft_sop       (ifft_sop),
        .ifft_eop       (ifft_eop),
        .ifft_bin       (ifft_bin),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [40:0] snap();
        return {ifft_valid, ifft_sop, ifft_eop, ifft_bin, ifft_inphase_o, ifft_quadrat_o};
    endfunction

    function automatic logic [31:0] exp_word(input int bin, input logic [31:0] s [N_USED]);
        if (bin >= N_FFT - HALF)       return s[bin - (N_FFT - HALF)];
        else if (bin >= 1 && bin <= HALF) return s[bin + HALF - 1];
        else                           return 32'h0;
    endfunction

    function automatic logic [31:0] ramp(input int v);
        return {16'(v), 16'(-v)};
    endfunction

    task automatic send_range(input logic [31:0] s [N_USED], input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            qam_mod_valid = 1'b1;
            {qam_inphase_i, qam_quadrat_i} = s[k];
            tick();
        end
        qam_mod_valid = 1'b0;
    endtask

    // Called right after the last sample's accepting edge.
    task automatic check_start(input string tag);
        check({tag, " lat1"}, 64'(ifft_valid), 64'(0));
        tick();
        check({tag, " lat2"}, 64'({ifft_valid, ifft_sop, ifft_bin}), 64'({1'b1, 1'b1, 6'd0}));
    endtask

    // Receives one full frame, checking every transfer, stall stability and
    // the idle cycle that follows the frame.
    task automatic recv_frame(input string tag, input logic [31:0] s [N_USED], input bit rnd);
        int bin = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [40:0] held = '0;
        while (bin < N_FFT && cyc < 4 * N_FFT + 100) begin
            if (stalled) check({tag, " hold"}, 64'(snap()), 64'(held));
            else if (bin > 0) check({tag, " valid"}, 64'(ifft_valid), 64'(1));
            ifft_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (ifft_valid) begin
                if (ifft_ready) begin
                    check($sformatf("%s bin%0d idx", tag, bin), 64'(ifft_bin), 64'(bin));
                    check($sformatf("%s bin%0d data", tag, bin),
                          64'({ifft_inphase_o, ifft_quadrat_o}), 64'(exp_word(bin, s)));
                    check($sformatf("%s bin%0d sop/eop", tag, bin), 64'({ifft_sop, ifft_eop}),
                          64'({bin == 0, bin == N_FFT - 1}));
                    bin++;
                end else begin
                    held    = snap();
                    stalled = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        ifft_ready = 1'b1;
        check({tag, " count"}, 64'(bin), 64'(N_FFT));
        check({tag, " gap"}, 64'(ifft_valid), 64'(0));
    endtask

    initial begin
        for (int k = 0; k < N_USED; k++) begin
            fa[k] = ramp(k);
            fb[k] = ramp(100 + k);
            fc[k] = ramp(200 + k);
            fd[k] = ramp(300 + k);
            fs[k] = (k % 2 == 0) ? 32'h8000_7FFF : 32'h7FFF_8000;
        end

        // ---------------- reset state ----------------
        reset         = 1'b0;
        qam_mod_valid = 1'b0;
        qam_inphase_i = '0;
        qam_quadrat_i = '0;
        ifft_ready    = 1'b1;
        tick();
        tick();
        check("reset outputs", 64'(snap()), 64'(0));
        check("reset overflow", 64'(overflow), 64'(0));
        reset = 1'b1;
        tick();

        // ---------------- ramp, ready high ----------------
        send_range(fa, 0, N_USED - 1);
        check_start("ramp");
        recv_frame("ramp", fa, 1'b0);

        // ---------------- ramp under backpressure ----------------
        send_range(fa, 0, N_USED - 1);
        check_start("bp");
        recv_frame("bp", fa, 1'b1);

        // ---------------- sign extremes ----------------
        send_range(fs, 0, N_USED - 1);
        check_start("sign");
        recv_frame("sign", fs, 1'b0);
        check("sign overflow", 64'(overflow), 64'(0));

        // ---------------- ping-pong with ready low ----------------
        ifft_ready = 1'b0;
        send_range(fb, 0, N_USED - 1);
        send_range(fc, 0, N_USED - 1);
        check("pp ovf before", 64'(overflow), 64'(0));
        send_range(fd, 0, 0);
        check("pp ovf first drop", 64'(overflow), 64'(1));
        send_range(fd, 1, N_USED - 1);
        check("pp stalled bin0", 64'({ifft_valid, ifft_sop, ifft_bin}), 64'({1'b1, 1'b1, 6'd0}));
        recv_frame("pp f1", fb, 1'b0);
        tick();
        check("pp f2 start", 64'({ifft_valid, ifft_sop}), 64'(2'b11));
        recv_frame("pp f2", fc, 1'b0);
        tick();
        check("pp no f3", 64'(ifft_valid), 64'(0));
        check("pp ovf sticky", 64'(overflow), 64'(1));

        // ---------------- boundary release ----------------
        reset = 1'b0;
        tick();
        check("rst2 overflow", 64'(overflow), 64'(0));
        reset = 1'b1;
        ifft_ready = 1'b0;
        send_range(fa, 0, N_USED - 1);
        send_range(fb, 0, N_USED - 1);
        check("br ovf before", 64'(overflow), 64'(0));
        ifft_ready = 1'b1;
        for (int c = 0; c < 200 && !(ifft_valid && ifft_eop); c++) tick();
        check("br at eop", 64'({ifft_valid, ifft_eop}), 64'(2'b11));
        qam_mod_valid = 1'b1;
        qam_inphase_i = 16'h1234;
        qam_quadrat_i = 16'h5678;
        tick();
        qam_mod_valid = 1'b0;
        ifft_ready    = 1'b0;
        check("br ovf set", 64'(overflow), 64'(1));
        check("br idle gap", 64'(ifft_valid), 64'(0));
        send_range(fc, 0, N_USED - 1);
        recv_frame("br f2", fb, 1'b0);
        tick();
        recv_frame("br f3", fc, 1'b0);

        // ---------------- reset mid-stream ----------------
        ifft_ready = 1'b0;
        send_range(fd, 0, N_USED - 1);
        tick();
        ifft_ready = 1'b1;
        send_range(fa, 0, 9);
        for (int c = 0; c < 10; c++) tick();
        check("mid bin20", 64'({ifft_valid, ifft_bin}), 64'({1'b1, 6'd20}));
        #2;
        reset = 1'b0;
        #1;
        check("mid async outputs", 64'(snap()), 64'(0));
        check("mid async overflow", 64'(overflow), 64'(0));
        tick();
        reset = 1'b1;
        tick();
        send_range(fb, 0, N_USED - 1);
        check_start("fresh");
        recv_frame("fresh", fb, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
